pipe_latch_elastic: RTL and testbench

Parametrised pipeline latch with valid/ready handshake, flush and stall accounting. It is the next-generation replacement for the fixed inter-stage latches (IF/ID … MEM/WB) in the MIPS pipeline. The payload splits into a data field, cleared to zero on reset, and a control field, forced to a programmable "bubble" value on reset, flush or empty. An optional skid buffer registers the ready path so that long stall chains do not form combinational loops.

---
 rtl/pipe_latch_elastic.sv | 108 ++++++++++
 tb/tb_pipe_latch_elastic.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_elastic.sv
// rtl/pipe_latch_elastic.sv - elastic pipeline latch with flush, bubble control and stall counter
// Define PIPE_SKID_EN for the 2-entry build with registered in_ready.
module pipe_latch_elastic #(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              accept;
    logic              release_beat;

    assign accept       = in_valid && in_ready && !flush;
    assign release_beat = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Registered ready: no combinational path from out_ready to in_ready.
    assign in_ready  = !skid_valid;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= CTRL_BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= CTRL_BUBBLE;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (release_beat || !main_valid) begin
            // Skid drains first; while it is full, accept cannot happen.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end
`else
    assign in_ready  = !main_valid || out_ready;
    assign occupancy = {1'b0, main_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= CTRL_BUBBLE;
        end else if (flush) begin
            main_valid <= 1'b0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
            main_ctrl  <= in_ctrl;
        end else if (release_beat) begin
            main_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// tb/tb_pipe_latch_elastic.sv - randomized and directed bench against a FIFO reference model
module tb_pipe_latch_elastic;

    localparam int             DW   = 32;
    localparam int             CW   = 8;
    localparam logic [CW-1:0]  BUB  = 8'hA5;
    localparam int             CNTW = 4;
    localparam int             CMAX = 15;
`ifdef PIPE_SKID_EN
    localparam int             CAP  = 2;
`else
    localparam int             CAP  = 1;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]   in_data, out_data;
    logic [CW-1:0]   in_ctrl, out_ctrl;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] stall_cnt;

    int    tests = 0;
    int    fails = 0;
    beat_t q[$];
    beat_t src[$];
    int    cnt_m = 0;
    bit    data_zero = 1'b0;
    int    max_occ = 0;

    pipe_latch_elastic #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input bit chk, input bit r, input bit f, input bit use_src, input bit ordy);
        bit    ev, er, acc, rel;
        beat_t b;
        @(negedge clk);
        b         = (src.size() > 0) ? src[0] : '0;
        reset     = r;
        flush     = f;
        in_valid  = use_src && (src.size() > 0);
        in_data   = b.d;
        in_ctrl   = b.c;
        out_ready = ordy;
        #1;
        ev = q.size() > 0;
        er = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
        if (chk) begin
            check("out_valid", out_valid, ev);
            check("in_ready", in_ready, er);
            check("occupancy", occupancy, q.size());
            check("stall_cnt", stall_cnt, cnt_m);
            if (ev) begin
                check("out_data", out_data, q[0].d);
                check("out_ctrl", out_ctrl, q[0].c);
            end else begin
                check("out_ctrl_bubble", out_ctrl, BUB);
            end
            if (data_zero) check("out_data_reset", out_data, 0);
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        @(posedge clk);
        acc = in_valid && er && !f;
        rel = ev && ordy;
        if (r) begin
            q.delete();
            cnt_m     = 0;
            data_zero = 1'b1;
        end else begin
            if (ev && !ordy && cnt_m < CMAX) cnt_m++;
            if (f) begin
                q.delete();
            end else begin
                if (rel) void'(q.pop_front());
                if (acc) begin
                    q.push_back(b);
                    data_zero = 1'b0;
                end
            end
        end
        // Upstream drops its beat on flush and retires it on accept.
        if (in_valid && (acc || (f && !r))) void'(src.pop_front());
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d);
        beat_t b;
        b.d = d;
        b.c = d[CW-1:0] ^ 8'h3C;
        return b;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;

        // Reset held for two cycles, then a back-to-back stream.
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        src.push_back(mk(32'h1)); src.push_back(mk(32'h2)); src.push_back(mk(32'h3));
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
        check("stream_drained", src.size(), 0);

        // Stall while streaming A, B, C, then release.
        src.push_back(mk(32'hA)); src.push_back(mk(32'hB)); src.push_back(mk(32'hC));
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        check("stall_occ_peak", max_occ, CAP);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);

        // Fill, then flush with D offered; D must never appear.
        src.push_back(mk(32'h10)); src.push_back(mk(32'h11));
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        src.delete();
        src.push_back(mk(32'hD));
        step(1, 0, 1, 1, 0);
        check("flush_dropped_d", src.size(), 0);
        step(1, 0, 0, 0, 1);

        // Stall counter saturation, unaffected by flush.
        src.push_back(mk(32'h20));
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        check("stall_sat", stall_cnt, 15);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        check("stall_after_flush", stall_cnt, 15);

        // Reset beats flush and an accept in the same cycle.
        src.push_back(mk(32'h5));
        step(1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 1);
        check("reset_prio_cnt", stall_cnt, 0);
        check("reset_prio_valid", out_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (src.size() < 3 && $urandom_range(0, 3) != 0) src.push_back(mk($urandom()));
            step(1, ($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0));
        end
        check("occ_bound", (max_occ <= CAP), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
